// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronizes the raw PS/2 lines, deserializes 11-bit frames
// and reports good scan codes or parity/framing errors as one-cycle pulses.
module ps2_scan_rx #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   prev_clk;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;

  logic [1:0]       state, state_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       sr, sr_nxt;
  logic             par, par_nxt;
  logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic [7:0]       scan_code_nxt;
  logic             scan_valid_nxt;
  logic             parity_err_nxt;
  logic             frame_err_nxt;
  logic             timeout;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall   = !clk_s && prev_clk;

  // Synchronizers and edge-detect flop idle at line level (high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      prev_clk  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      prev_clk  <= clk_s;
    end
  end

  // State, datapath and registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      sr         <= 8'd0;
      par        <= 1'b0;
      tmo_cnt    <= '0;
      scan_code  <= 8'd0;
      scan_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      sr         <= sr_nxt;
      par        <= par_nxt;
      tmo_cnt    <= tmo_cnt_nxt;
      scan_code  <= scan_code_nxt;
      scan_valid <= scan_valid_nxt;
      parity_err <= parity_err_nxt;
      frame_err  <= frame_err_nxt;
    end
  end

  assign timeout = (state != IDLE) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Frame sequencing; a fall always beats a coincident timeout
  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    sr_nxt         = sr;
    par_nxt        = par;
    tmo_cnt_nxt    = (state == IDLE) ? '0 : tmo_cnt + CNT_W'(1);
    scan_code_nxt  = scan_code;
    scan_valid_nxt = 1'b0;
    parity_err_nxt = 1'b0;
    frame_err_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (fall && !data_s) begin
          state_nxt   = DATA;
          bit_cnt_nxt = 3'd0;
        end
      end
      DATA: begin
        if (fall) begin
          sr_nxt      = {data_s, sr[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_nxt   = data_s;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_nxt = IDLE;
          if (!data_s) begin
            frame_err_nxt = 1'b1;
          end else if (^{sr, par} == 1'b0) begin
            parity_err_nxt = 1'b1;
          end else begin
            scan_code_nxt  = sr;
            scan_valid_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (fall) begin
      tmo_cnt_nxt = '0;
    end else if (timeout) begin
      state_nxt     = IDLE;
      frame_err_nxt = 1'b1;
      tmo_cnt_nxt   = '0;
    end
  end

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: drives PS/2 frames from a simple line model and
// compares decoded codes and error pulses against hand-computed values.
module tb_ps2_scan_rx;

  localparam int unsigned SYNC = 2;
  localparam int unsigned TMO  = 200;
  localparam int unsigned HALF = 20;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       parity_err;
  logic       frame_err;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  int n_valid = 0, n_perr = 0, n_ferr = 0, n_multi = 0;
  int fall_cyc = 0, fe_cyc = 0;
  logic [7:0] codes[$];

  ps2_scan_rx #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Pulse monitor sampled on the falling clk edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (scan_valid) begin
        n_valid++;
        codes.push_back(scan_code);
      end
      if (parity_err) n_perr++;
      if (frame_err) begin
        n_ferr++;
        fe_cyc = cyc;
      end
      if ((int'(scan_valid) + int'(parity_err) + int'(frame_err)) > 1) n_multi++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    n_valid = 0;
    n_perr  = 0;
    n_ferr  = 0;
    codes.delete();
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(stop);
    @(negedge clk) ps2_data = 1'b1;
  endtask

  task automatic settle();
    repeat (10) @(negedge clk);
  endtask

  function automatic logic [31:0] code_at(input int idx);
    return (idx < codes.size()) ? 32'(codes[idx]) : 32'hFFFF_FFFF;
  endfunction

  initial begin
    repeat (4) @(negedge clk);
    check("rst_scan_code", 32'(scan_code), 32'h00);
    check("rst_pulses", {29'd0, scan_valid, parity_err, frame_err}, 32'h0);
    rst_n = 1'b1;
    settle();

    // Test 1: 0x70 has three ones -> odd parity bit 0
    clear_counts();
    send_frame(8'h70, 1'b0, 1'b1);
    settle();
    check("t1_valid_cnt", 32'(n_valid), 32'd1);
    check("t1_code", code_at(0), 32'h70);
    check("t1_no_err", 32'(n_perr + n_ferr), 32'd0);

    // Test 2: back-to-back 0xF0 and 0x69 (both four ones -> p=1)
    clear_counts();
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h69, 1'b1, 1'b1);
    settle();
    check("t2_valid_cnt", 32'(n_valid), 32'd2);
    check("t2_code0", code_at(0), 32'hF0);
    check("t2_code1", code_at(1), 32'h69);
    check("t2_no_err", 32'(n_perr + n_ferr), 32'd0);

    // Test 3: 0x7A has five ones, p=1 is wrong
    clear_counts();
    send_frame(8'h7A, 1'b1, 1'b1);
    settle();
    check("t3_perr_cnt", 32'(n_perr), 32'd1);
    check("t3_no_valid", 32'(n_valid + n_ferr), 32'd0);
    check("t3_code_held", 32'(scan_code), 32'h69);

    // Test 4: bad stop with bad parity -> framing error only, then clean 0x75
    clear_counts();
    send_frame(8'h75, 1'b1, 1'b0);
    settle();
    check("t4_ferr_cnt", 32'(n_ferr), 32'd1);
    check("t4_no_perr", 32'(n_perr + n_valid), 32'd0);
    check("t4_code_held", 32'(scan_code), 32'h69);
    clear_counts();
    send_frame(8'h75, 1'b0, 1'b1);
    settle();
    check("t4_clean_valid", 32'(n_valid), 32'd1);
    check("t4_clean_code", code_at(0), 32'h75);

    // Test 5: stall after four data bits; timeout lands TMO+SYNC+1 cycles after the pin fall
    clear_counts();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (TMO + 40) @(negedge clk);
    ps2_data = 1'b1;
    check("t5_ferr_cnt", 32'(n_ferr), 32'd1);
    check("t5_ferr_time", 32'(fe_cyc - fall_cyc), 32'(TMO + SYNC + 1));
    check("t5_no_other", 32'(n_valid + n_perr), 32'd0);
    clear_counts();
    send_frame(8'h6B, 1'b0, 1'b1);
    settle();
    check("t5_clean_valid", 32'(n_valid), 32'd1);
    check("t5_clean_code", code_at(0), 32'h6B);

    // Test 6a: asynchronous reset in the middle of the data bits
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk);
    rst_n    = 1'b0;
    ps2_data = 1'b1;
    #1;
    check("t6a_async_code", 32'(scan_code), 32'h00);
    check("t6a_async_pulses", {29'd0, scan_valid, parity_err, frame_err}, 32'h0);
    repeat (5) @(negedge clk);
    clear_counts();
    rst_n = 1'b1;
    repeat (TMO + 40) @(negedge clk);
    check("t6a_quiet", 32'(n_valid + n_perr + n_ferr), 32'd0);
    send_frame(8'h73, 1'b0, 1'b1);
    settle();
    check("t6a_valid", 32'(n_valid), 32'd1);
    check("t6a_code", code_at(0), 32'h73);

    // Test 6b: data glitches high exactly when the start-bit fall is sampled
    clear_counts();
    @(negedge clk) ps2_data = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk  = 1'b0;
    ps2_data = 1'b1;
    @(negedge clk) ps2_data = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (TMO + 40) @(negedge clk);
    check("t6b_silent", 32'(n_valid + n_perr + n_ferr), 32'd0);
    check("t6b_code_held", 32'(scan_code), 32'h73);
    send_frame(8'h70, 1'b0, 1'b1);
    settle();
    check("t6b_after_code", code_at(0), 32'h70);

    check("one_hot_pulses", 32'(n_multi), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
